// File: rtl/hazard_ctrl.sv
// Pipeline interlock between the ID and EX stage registers: load/mfc0-use bubbles, HI/LO busy interlock, branch flush.
// Optional stall-cycle statistics counter is compiled in when HAZARD_STAT_EN is defined.
module hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int MD_LATENCY   = 32,
    parameter int CNT_W        = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_mfhilo,
    input  logic              id_md,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_MemRead,
    input  logic              ex_Mfc0,
    input  logic              ex_md_start,
    input  logic              ex_branch_taken,
    output logic              PC_IFWrite,
    output logic              ID_EX_stall,
    output logic              IF_ID_flush,
    output logic              md_busy
`ifdef HAZARD_STAT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        LWAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] BCNT_INIT = CNT_W'(LOAD_BUBBLES - 1);
    localparam logic [CNT_W-1:0] MD_INIT   = CNT_W'(MD_LATENCY);
    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] bcnt_r;
    logic [CNT_W-1:0] bcnt_nxt_s;
    logic [CNT_W-1:0] mdcnt_r;
    logic             hit_s;
    logic             load_stall_s;
    logic             md_stall_s;

    // Load/mfc0-use hazard detection; register 0 is never a real producer.
    always_comb begin
        hit_s = 1'b0;
        if ((ex_MemRead | ex_Mfc0) && (ex_rt != REG_ZERO)) begin
            hit_s = (id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt));
        end else begin
            hit_s = 1'b0;
        end
    end

    // Bubble FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= IDLE;
            bcnt_r  <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            bcnt_r  <= bcnt_nxt_s;
        end
    end

    // Bubble FSM next state; a taken branch abandons the remaining bubbles.
    always_comb begin
        state_nxt_s = state_r;
        bcnt_nxt_s  = bcnt_r;
        case (state_r)
            IDLE: begin
                if (hit_s && (LOAD_BUBBLES > 1)) begin
                    state_nxt_s = LWAIT;
                    bcnt_nxt_s  = BCNT_INIT;
                end else begin
                    state_nxt_s = IDLE;
                    bcnt_nxt_s  = bcnt_r;
                end
            end
            LWAIT: begin
                if (ex_branch_taken || (bcnt_r == CNT_ONE)) begin
                    state_nxt_s = IDLE;
                    bcnt_nxt_s  = CNT_ZERO;
                end else begin
                    state_nxt_s = LWAIT;
                    bcnt_nxt_s  = bcnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                bcnt_nxt_s  = CNT_ZERO;
            end
        endcase
    end

    // Mult/div busy counter: a new start always reloads, otherwise count down to zero and hold.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mdcnt_r <= CNT_ZERO;
        end else if (ex_md_start) begin
            mdcnt_r <= MD_INIT;
        end else if (mdcnt_r != CNT_ZERO) begin
            mdcnt_r <= mdcnt_r - CNT_ONE;
        end else begin
            mdcnt_r <= CNT_ZERO;
        end
    end

    // Output decode; flush overrides the PC hold so the branch target is fetched.
    always_comb begin
        load_stall_s = 1'b0;
        md_stall_s   = 1'b0;
        md_busy      = 1'b0;
        ID_EX_stall  = 1'b0;
        PC_IFWrite   = 1'b1;
        IF_ID_flush  = 1'b0;
        case (state_r)
            IDLE:    load_stall_s = hit_s;
            LWAIT:   load_stall_s = 1'b1;
            default: load_stall_s = 1'b0;
        endcase
        md_busy     = (mdcnt_r != CNT_ZERO);
        md_stall_s  = md_busy && (id_mfhilo || id_md);
        ID_EX_stall = load_stall_s || md_stall_s;
        IF_ID_flush = ex_branch_taken;
        if (ex_branch_taken) begin
            PC_IFWrite = 1'b1;
        end else begin
            PC_IFWrite = !ID_EX_stall;
        end
    end

`ifdef HAZARD_STAT_EN
    logic [15:0] stat_r;

    // Saturating count of cycles in which the front end was held.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_r <= 16'h0000;
        end else if (!PC_IFWrite && (stat_r != 16'hFFFF)) begin
            stat_r <= stat_r + 16'h0001;
        end else begin
            stat_r <= stat_r;
        end
    end

    assign stall_cycles = stat_r;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: two hazard_ctrl instances (default and LOAD_BUBBLES=3/MD_LATENCY=4) share stimulus
// and are compared every cycle against a timestamp-based reference model.
module tb_hazard_ctrl;

    logic       clock;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_use_rs, id_use_rt, id_mfhilo, id_md;
    logic       ex_MemRead, ex_Mfc0, ex_md_start, ex_branch_taken;
    logic [1:0] pcw_w, idex_w, flush_w, busy_w;
    logic [15:0] stat_w [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;
    int lbv [2]  = '{1, 3};
    int mdv [2]  = '{32, 4};
    int load_end [2] = '{0, 0};
    int md_end   [2] = '{0, 0};
    int stat_m   [2] = '{0, 0};

    hazard_ctrl dut_d (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_mfhilo(id_mfhilo), .id_md(id_md), .ex_rt(ex_rt),
        .ex_MemRead(ex_MemRead), .ex_Mfc0(ex_Mfc0), .ex_md_start(ex_md_start),
        .ex_branch_taken(ex_branch_taken),
        .PC_IFWrite(pcw_w[0]), .ID_EX_stall(idex_w[0]), .IF_ID_flush(flush_w[0]), .md_busy(busy_w[0])
`ifdef HAZARD_STAT_EN
        , .stall_cycles(stat_w[0])
`endif
    );

    hazard_ctrl #(.LOAD_BUBBLES(3), .MD_LATENCY(4)) dut_p (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_mfhilo(id_mfhilo), .id_md(id_md), .ex_rt(ex_rt),
        .ex_MemRead(ex_MemRead), .ex_Mfc0(ex_Mfc0), .ex_md_start(ex_md_start),
        .ex_branch_taken(ex_branch_taken),
        .PC_IFWrite(pcw_w[1]), .ID_EX_stall(idex_w[1]), .IF_ID_flush(flush_w[1]), .md_busy(busy_w[1])
`ifdef HAZARD_STAT_EN
        , .stall_cycles(stat_w[1])
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Constant expectation for one instance in the current cycle (inputs already settled).
    task automatic expect_now(input string tag, input int k, input logic e_idex, input logic e_pcw, input logic e_busy);
        check_eq({tag, ".ID_EX_stall"}, 32'(idex_w[k]), 32'(e_idex));
        check_eq({tag, ".PC_IFWrite"}, 32'(pcw_w[k]), 32'(e_pcw));
        check_eq({tag, ".md_busy"}, 32'(busy_w[k]), 32'(e_busy));
    endtask

    // One clock cycle: compare both instances against the model, then advance the model.
    task automatic tick();
        logic hit, in_wait, busy, idex, pcw;
        @(negedge clock);
        hit = (ex_MemRead || ex_Mfc0) && (ex_rt != 5'd0) &&
              ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
        for (int k = 0; k < 2; k++) begin
            in_wait = (cyc < load_end[k]);
            busy    = (cyc < md_end[k]);
            idex    = in_wait || hit || (busy && (id_mfhilo || id_md));
            pcw     = !idex || ex_branch_taken;
            if (chk_en) begin
                check_eq($sformatf("c%0d.d%0d.ID_EX_stall", cyc, k), 32'(idex_w[k]), 32'(idex));
                check_eq($sformatf("c%0d.d%0d.PC_IFWrite", cyc, k), 32'(pcw_w[k]), 32'(pcw));
                check_eq($sformatf("c%0d.d%0d.IF_ID_flush", cyc, k), 32'(flush_w[k]), 32'(ex_branch_taken));
                check_eq($sformatf("c%0d.d%0d.md_busy", cyc, k), 32'(busy_w[k]), 32'(busy));
`ifdef HAZARD_STAT_EN
                check_eq($sformatf("c%0d.d%0d.stall_cycles", cyc, k), 32'(stat_w[k]), 32'(stat_m[k]));
`endif
            end
            if (!in_wait && hit) load_end[k] = cyc + lbv[k];
            else if (in_wait && ex_branch_taken) load_end[k] = cyc + 1;
            if (ex_md_start) md_end[k] = cyc + 1 + mdv[k];
            if (!pcw && stat_m[k] < 65535) stat_m[k]++;
            if (!reset) begin
                load_end[k] = cyc + 1;
                md_end[k]   = cyc + 1;
                stat_m[k]   = 0;
            end
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_mfhilo = 1'b0; id_md = 1'b0;
        ex_MemRead = 1'b0; ex_Mfc0 = 1'b0; ex_md_start = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic load_hit();
        ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        @(posedge clock); #1;
        tick();
        tick();
        reset = 1'b1;
        chk_en = 1'b1;
        #1;
        expect_now("rst_d", 0, 1'b0, 1'b1, 1'b0);
        expect_now("rst_p", 1, 1'b0, 1'b1, 1'b0);
        tick();

        // Load-use: one bubble on the default instance, three on the LOAD_BUBBLES=3 instance.
        load_hit(); #1;
        expect_now("lu_d0", 0, 1'b1, 1'b0, 1'b0);
        expect_now("lu_p0", 1, 1'b1, 1'b0, 1'b0);
        tick();
        idle_inputs(); #1;
        expect_now("lu_d1", 0, 1'b0, 1'b1, 1'b0);
        expect_now("lu_p1", 1, 1'b1, 1'b0, 1'b0);
        tick(); #1;
        expect_now("lu_p2", 1, 1'b1, 1'b0, 1'b0);
        tick(); #1;
        expect_now("lu_p3", 1, 1'b0, 1'b1, 1'b0);

        // Register 0 never hazards.
        ex_MemRead = 1'b1; id_use_rs = 1'b1; #1;
        expect_now("r0_d", 0, 1'b0, 1'b1, 1'b0);
        expect_now("r0_p", 1, 1'b0, 1'b1, 1'b0);
        tick();

        // Taken branch in the second bubble cycle aborts the wait.
        idle_inputs(); load_hit(); ex_MemRead = 1'b0; ex_Mfc0 = 1'b1;
        tick();
        idle_inputs(); ex_branch_taken = 1'b1; #1;
        expect_now("lbr_p1", 1, 1'b1, 1'b1, 1'b0);
        check_eq("lbr_flush", 32'(flush_w[1]), 32'd1);
        tick();
        idle_inputs(); #1;
        expect_now("lbr_p2", 1, 1'b0, 1'b1, 1'b0);
        tick();

        // MD_LATENCY=4: busy and mfhi interlock for cycles 1-4.
        ex_md_start = 1'b1;
        tick();
        ex_md_start = 1'b0; id_mfhilo = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            expect_now($sformatf("md_c%0d", i), 1, 1'b1, 1'b0, 1'b1);
            tick();
        end
        #1;
        expect_now("md_c5", 1, 1'b0, 1'b1, 1'b0);
        tick();

        // Back-to-back mult: restart as the counter reaches 1 reloads a full latency.
        idle_inputs(); id_md = 1'b1; ex_md_start = 1'b1;
        tick();
        ex_md_start = 1'b0;
        tick(); tick(); tick();
        ex_md_start = 1'b1; #1;
        expect_now("b2b_last", 1, 1'b1, 1'b0, 1'b1);
        tick();
        ex_md_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            expect_now($sformatf("b2b_r%0d", i), 1, 1'b1, 1'b0, 1'b1);
            tick();
        end
        #1;
        expect_now("b2b_done", 1, 1'b0, 1'b1, 1'b0);
        tick();

        // Branch with concurrent load hit: flush and fetch, but bubble ID/EX.
        idle_inputs();
        repeat (40) tick();
        load_hit(); ex_branch_taken = 1'b1; #1;
        expect_now("brst_d", 0, 1'b1, 1'b1, 1'b0);
        check_eq("brst_flush", 32'(flush_w[0]), 32'd1);
        tick();
        idle_inputs();
        repeat (4) tick();

        // Reset during LWAIT with the default instance's counter at 10.
        ex_md_start = 1'b1;
        tick();
        ex_md_start = 1'b0;
        repeat (21) tick();
        load_hit();
        tick();
        idle_inputs(); reset = 1'b0;
        tick();
        reset = 1'b1; #1;
        expect_now("rmid_d", 0, 1'b0, 1'b1, 1'b0);
        expect_now("rmid_p", 1, 1'b0, 1'b1, 1'b0);
`ifdef HAZARD_STAT_EN
        check_eq("rmid_stat_d", 32'(stat_w[0]), 32'd0);
        check_eq("rmid_stat_p", 32'(stat_w[1]), 32'd0);
`endif
        tick();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 199) != 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            id_use_rs       = 1'($urandom_range(0, 1));
            id_use_rt       = 1'($urandom_range(0, 1));
            id_mfhilo       = ($urandom_range(0, 3) == 0);
            id_md           = ($urandom_range(0, 3) == 0);
            ex_MemRead      = ($urandom_range(0, 2) == 0);
            ex_Mfc0         = ($urandom_range(0, 5) == 0);
            ex_md_start     = ($urandom_range(0, 15) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
